// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester and multiplier-side signal bundle for mult_arbiter
// slave is the arbiter's view; master is the view of the requesters and the multiplier.
interface mult_arbiter_if #(
  parameter int N = 4
);
  logic         req0;
  logic         req1;
  logic [N-1:0] a0;
  logic [N-1:0] b0;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  logic         ack0;
  logic         ack1;
  logic [N-1:0] result;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic         owner;
  logic         busy;
  logic         mul_rst;
  logic [N-1:0] mul_a;
  logic [N-1:0] mul_b;
  logic [N-1:0] mul_result;
  logic         mul_overflow;
  logic         mul_zero;
  logic         mul_negative;

  modport slave (
    input  req0, req1, a0, b0, a1, b1,
    input  mul_result, mul_overflow, mul_zero, mul_negative,
    output ack0, ack1, result, overflow, zero, negative, owner, busy,
    output mul_rst, mul_a, mul_b
  );

  modport master (
    output req0, req1, a0, b0, a1, b1,
    output mul_result, mul_overflow, mul_zero, mul_negative,
    input  ack0, ack1, result, overflow, zero, negative, owner, busy,
    input  mul_rst, mul_a, mul_b
  );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sharing of one sequential multiplier between two requesters
// Optional MULT_ARB_ZERO_BYPASS_EN: zero-operand requests complete without running the multiplier.
module mult_arbiter #(
  parameter int N       = 4,
  parameter int LATENCY = 5
) (
  input  logic            clk,
  input  logic            rst,
  mult_arbiter_if.slave   bus
);
  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic          last_grant;
  logic          winner;
  logic [CW-1:0] cnt;
  logic          any_req;
  logic          grant;
  logic          bypass;
  logic [N-1:0]  grant_a;
  logic [N-1:0]  grant_b;

  assign any_req = bus.req0 | bus.req1;
  // On a tie the requester that did not win last time gets the multiplier.
  assign grant   = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
  assign grant_a = grant ? bus.a1 : bus.a0;
  assign grant_b = grant ? bus.b1 : bus.b0;

`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign bypass = (grant_a == '0) || (grant_b == '0);
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    bus.busy    = 1'b1;
    bus.mul_rst = 1'b1;
    bus.ack0    = 1'b0;
    bus.ack1    = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (any_req) begin
          state_next = bypass ? DONE : LOAD;
        end
      end
      LOAD: begin
        state_next = RUN;
      end
      RUN: begin
        bus.mul_rst = 1'b0;
        if (cnt == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.ack0   = ~winner;
        bus.ack1   = winner;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands latch at grant; the visible result/flags/owner change only on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant   <= 1'b1;
      winner       <= 1'b0;
      cnt          <= '0;
      bus.mul_a    <= '0;
      bus.mul_b    <= '0;
      bus.result   <= '0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b0;
      bus.negative <= 1'b0;
      bus.owner    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= grant;
            winner     <= grant;
            bus.mul_a  <= grant_a;
            bus.mul_b  <= grant_b;
            if (bypass) begin
              bus.result   <= '0;
              bus.overflow <= 1'b0;
              bus.zero     <= 1'b1;
              bus.negative <= 1'b0;
              bus.owner    <= grant;
            end
          end
        end
        LOAD: begin
          cnt <= '0;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            bus.result   <= bus.mul_result;
            bus.overflow <= bus.mul_overflow;
            bus.zero     <= bus.mul_zero;
            bus.negative <= bus.mul_negative;
            bus.owner    <= winner;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - randomized and directed bench for mult_arbiter
// Includes a timing-accurate multiplier stand-in that outputs garbage until its latency elapses.
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int L = 5;
`ifdef MULT_ARB_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  mult_arbiter_if #(.N(N)) bus ();

  mult_arbiter #(.N(N), .LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: correct product only once it has seen L-1 edges out of reset.
  int           mcnt = 0;
  logic [2*N-1:0] prod;
  logic         mvalid;
  assign prod   = bus.mul_a * bus.mul_b;
  assign mvalid = !bus.mul_rst && (mcnt >= L - 1);
  assign bus.mul_result   = mvalid ? prod[N-1:0] : ~prod[N-1:0];
  assign bus.mul_overflow = mvalid ? (prod[2*N-1:N] != '0) : (prod[2*N-1:N] == '0);
  assign bus.mul_zero     = mvalid ? (prod[N-1:0] == '0) : (prod[N-1:0] != '0);
  assign bus.mul_negative = mvalid ? prod[N-1] : ~prod[N-1];
  always @(posedge clk) mcnt <= bus.mul_rst ? 0 : mcnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 idle, 1 serving (m_rem edges left until ack), 2 ack cycle.
  int           m_phase = 0;
  int           m_rem   = 0;
  bit           m_last  = 1'b1;
  bit           m_own   = 1'b0;
  logic [N-1:0] m_a     = '0;
  logic [N-1:0] m_b     = '0;
  logic [N-1:0] e_result = '0;
  bit           e_ovf = 0, e_zero = 0, e_neg = 0, e_owner = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_rem <= 0; m_last <= 1'b1; m_own <= 1'b0;
      m_a <= '0; m_b <= '0; e_result <= '0;
      e_ovf <= 0; e_zero <= 0; e_neg <= 0; e_owner <= 0;
    end else begin
      bit             w;
      logic [N-1:0]   wa, wb;
      logic [2*N-1:0] p;
      case (m_phase)
        0: if (bus.req0 || bus.req1) begin
          w  = (bus.req0 && bus.req1) ? !m_last : bus.req1;
          wa = w ? bus.a1 : bus.a0;
          wb = w ? bus.b1 : bus.b0;
          m_last <= w; m_own <= w; m_a <= wa; m_b <= wb;
          if (BYP && (wa == '0 || wb == '0)) begin
            m_phase <= 2; e_result <= '0; e_zero <= 1; e_ovf <= 0; e_neg <= 0; e_owner <= w;
          end else begin
            m_phase <= 1; m_rem <= L + 1;
          end
        end
        1: if (m_rem == 1) begin
          p = m_a * m_b;
          m_phase  <= 2;
          e_result <= p[N-1:0];
          e_ovf    <= (p[2*N-1:N] != '0);
          e_zero   <= (p[N-1:0] == '0);
          e_neg    <= p[N-1];
          e_owner  <= m_own;
        end else begin
          m_rem <= m_rem - 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("ack0",     bus.ack0,     (m_phase == 2) && !m_own);
    chk("ack1",     bus.ack1,     (m_phase == 2) && m_own);
    chk("busy",     bus.busy,     m_phase != 0);
    chk("mul_rst",  bus.mul_rst,  !(m_phase == 1 && m_rem <= L));
    chk("result",   bus.result,   e_result);
    chk("overflow", bus.overflow, e_ovf);
    chk("zero",     bus.zero,     e_zero);
    chk("negative", bus.negative, e_neg);
    chk("owner",    bus.owner,    e_owner);
    chk("mul_a",    bus.mul_a,    m_a);
    chk("mul_b",    bus.mul_b,    m_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int who, input logic r, input logic [N-1:0] a, input logic [N-1:0] b);
    if (who == 0) begin bus.req0 = r; bus.a0 = a; bus.b0 = b; end
    else begin bus.req1 = r; bus.a1 = a; bus.b1 = b; end
  endtask

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    v = N'($urandom);
    if ($urandom_range(0, 3) == 0) v = '0;
    return v;
  endfunction

  task automatic wait_ack(input int who, output int at, output int lows, output int first_low,
                          output int others);
    at = -1; lows = 0; first_low = -1; others = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!bus.mul_rst) begin
        lows++;
        if (first_low < 0) first_low = cyc;
      end
      if (who == 0 ? bus.ack1 : bus.ack0) others++;
      if (who == 0 ? bus.ack0 : bus.ack1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"},    bus.busy,    0);
    chk({tag, "_mul_rst"}, bus.mul_rst, 1);
    chk({tag, "_acks"},    {bus.ack0, bus.ack1}, 0);
    chk({tag, "_result"},  bus.result,  0);
    chk({tag, "_flags"},   {bus.overflow, bus.zero, bus.negative}, 0);
    chk({tag, "_owner"},   bus.owner,   0);
    chk({tag, "_mul_ab"},  {bus.mul_a, bus.mul_b}, 0);
  endtask

  task automatic requester(input int who, input int n);
    int gap;
    bit got;
    for (int t = 0; t < n; t++) begin
      drive(who, 1'b1, rand_op(), rand_op());
      got = 0;
      for (int k = 0; k < 60 && !got; k++) begin
        step();
        if (who == 0 ? bus.ack0 : bus.ack1) got = 1;
        else drive(who, 1'b1, rand_op(), rand_op());
      end
      chk($sformatf("rand_ack_seen%0d", who), got, 1);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        drive(who, 1'b0, rand_op(), rand_op());
        repeat (gap) step();
      end
    end
    drive(who, 1'b0, '0, '0);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int c, at, lows, fl, oth, prev, prev_cyc, who, seen;
    bit found;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    repeat (2) step();
    check_reset_values("por");
    rst = 1'b1;

    // single request, 5 x 2
    step(); c = cyc;
    drive(0, 1'b1, 4'b0101, 4'b0010);
    wait_ack(0, at, lows, fl, oth);
    drive(0, 1'b0, '0, '0);
    chk("t2_ack_cycle", at, c + 7);
    chk("t2_result", bus.result, 4'b1010);
    chk("t2_owner", bus.owner, 0);
    chk("t2_mul_rst_lows", lows, 5);
    chk("t2_first_low", fl, c + 2);
    chk("t2_no_ack1", oth, 0);

    // mid-stream reset
    step(); rst = 1'b0; #1;
    check_reset_values("rst_mid");
    step(); rst = 1'b1;

    // tie right after reset: requester 0 first
    step(); c = cyc;
    drive(0, 1'b1, 4'b1001, 4'b0101);
    drive(1, 1'b1, 4'b1111, 4'b1111);
    wait_ack(0, at, lows, fl, oth);
    drive(0, 1'b0, '0, '0);
    chk("t3_ack0_cycle", at, c + 7);
    chk("t3_result0", bus.result, 4'b1101);
    chk("t3_owner0", bus.owner, 0);
    chk("t3_no_ack1_first", oth, 0);
    wait_ack(1, at, lows, fl, oth);
    drive(1, 1'b0, '0, '0);
    chk("t3_ack1_cycle", at, c + 15);
    chk("t3_result1", bus.result, 4'b0001);
    chk("t3_owner1", bus.owner, 1);

    // both held continuously: strict alternation every L+3 cycles
    step();
    drive(0, 1'b1, rand_op(), rand_op());
    drive(1, 1'b1, rand_op(), rand_op());
    prev = -1; prev_cyc = 0;
    for (int k = 0; k < 8; k++) begin
      found = 0;
      for (int j = 0; j < 20 && !found; j++) begin
        step();
        if (bus.ack0 || bus.ack1) found = 1;
      end
      chk("t4_ack_seen", found, 1);
      chk("t4_single_ack", bus.ack0 & bus.ack1, 0);
      who = bus.ack1 ? 1 : 0;
      if (k == 0) chk("t4_first_winner", who, 0);
      else begin
        chk("t4_alternate", who, prev ^ 1);
        chk("t4_period", cyc - prev_cyc, 8);
      end
      prev = who; prev_cyc = cyc;
      if (k == 7) begin
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
      end else begin
        drive(who, 1'b1, rand_op(), rand_op());
      end
    end
    repeat (2) step();

    // reset during RUN drops the operation
    step(); c = cyc;
    drive(1, 1'b1, 4'b1011, 4'b0010);
    repeat (3) step();
    rst = 1'b0; #1;
    check_reset_values("t5_rst");
    drive(1, 1'b0, '0, '0);
    seen = 0;
    repeat (2) begin
      step();
      if (bus.ack1) seen++;
    end
    chk("t5_no_ack1", seen, 0);
    rst = 1'b1;
    step(); c = cyc;
    drive(1, 1'b1, 4'b1011, 4'b0010);
    wait_ack(1, at, lows, fl, oth);
    drive(1, 1'b0, '0, '0);
    chk("t5_ack_cycle", at, c + 7);
    chk("t5_result", bus.result, 4'b0110);
    chk("t5_owner", bus.owner, 1);

    // zero operand
    step(); c = cyc;
    drive(0, 1'b1, 4'b0000, 4'b0111);
    wait_ack(0, at, lows, fl, oth);
    drive(0, 1'b0, '0, '0);
    chk("t6_ack_cycle", at, BYP ? c + 1 : c + 7);
    chk("t6_result", bus.result, 0);
    chk("t6_zero", bus.zero, 1);
    chk("t6_mul_rst_lows", lows, BYP ? 0 : 5);

    // request dropped during RUN still completes
    step(); c = cyc;
    drive(0, 1'b1, 4'b0011, 4'b0011);
    repeat (3) step();
    drive(0, 1'b0, '0, '0);
    wait_ack(0, at, lows, fl, oth);
    chk("t7_ack_cycle", at, c + 7);
    chk("t7_result", bus.result, 4'b1001);

    // randomized traffic from both requesters
    fork
      requester(0, 25);
      requester(1, 25);
    join
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
